// File: rtl/vga_seq_pkg.sv
// Shared definitions for the VGA frame sequencer: state encoding,
// frame geometry and the default millisecond prescale.
package vga_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } seq_state_t;

    // One frame fills the whole 16-word frame RAM.
    localparam int FRAME_WORDS    = 16;

    // 40 MHz clock -> 40000 cycles per millisecond.
    localparam int DEF_CLK_PER_MS = 40000;

endpackage

// File: rtl/ms_timer.sv
// Millisecond hold timer: a prescaler wrapping every CLK_PER_MS cycles
// feeding a millisecond counter. While run is high, expire pulses in the
// last cycle of the programmed hold; a hold of 0 expires on the first
// cycle, so the hold always lasts at least one cycle.
module ms_timer
#(
    parameter int CLK_PER_MS = vga_seq_pkg::DEF_CLK_PER_MS
)
(
    input  logic       CLK_40Mhz,
    input  logic       RSTn,
    input  logic       clear,
    input  logic       run,
    input  logic [9:0] hold_ms,
    output logic       expire
);
    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    logic [PW-1:0] pre_reg;
    logic [9:0]    ms_reg;
    logic          pre_wrap;

    assign pre_wrap = (pre_reg == PW'(CLK_PER_MS - 1));
    assign expire   = run && ((hold_ms == 10'd0) ||
                              (pre_wrap && (ms_reg == hold_ms - 10'd1)));

    // Prescaler and millisecond counter; cleared whenever the hold is not active.
    always_ff @(posedge CLK_40Mhz or negedge RSTn) begin
        if (!RSTn) begin
            pre_reg <= '0;
            ms_reg  <= '0;
        end else if (clear) begin
            pre_reg <= '0;
            ms_reg  <= '0;
        end else if (run) begin
            if (pre_wrap) begin
                pre_reg <= '0;
                ms_reg  <= ms_reg + 10'd1;
            end else begin
                pre_reg <= pre_reg + PW'(1);
            end
        end
    end

endmodule

// File: rtl/vga_frame_sequencer.sv
// Streams 16-word glyph frames from the font ROM into the vga_interface
// frame RAM, holding each frame for a programmable number of milliseconds.
// The ROM answers one cycle after its address, so the write enable and
// address are delayed one stage while the data passes straight through.
// Optional build macro FRAME_SEQ_HOST_PORT_EN adds a host write port that
// is granted the RAM port only outside FETCH.
module vga_frame_sequencer
#(
    parameter int CLK_PER_MS  = vga_seq_pkg::DEF_CLK_PER_MS,
    parameter int FRAME_WORDS = vga_seq_pkg::FRAME_WORDS,
    parameter int ROM_AW      = 7
)
(
    input  logic              CLK_40Mhz,
    input  logic              RSTn,
    input  logic              Start_Sig,
    input  logic              Stop_Sig,
    input  logic [2:0]        Frame_Last,
    input  logic [9:0]        Hold_Ms,
    input  logic              Loop_En,
    output logic [ROM_AW-1:0] Rom_Addr,
    input  logic [15:0]       Rom_Data,
    output logic              Write_En_Sig,
    output logic [3:0]        Write_Addr_Sig,
    output logic [15:0]       Write_Data,
    output logic [2:0]        Frame_Idx,
    output logic              Busy,
    output logic              Frame_Done_Sig,
    output logic              Seq_Done_Sig
`ifdef FRAME_SEQ_HOST_PORT_EN
    ,
    input  logic              Host_Req,
    input  logic [3:0]        Host_Addr,
    input  logic [15:0]       Host_Data,
    output logic              Host_Ack
`endif
);
    import vga_seq_pkg::*;

    seq_state_t  state_reg;
    logic [2:0]  frame_reg;
    logic [2:0]  last_reg;
    logic [9:0]  hold_reg;
    logic [4:0]  cnt_reg;        // 0..15 issue words, 16 is the drain cycle
    logic        frame_done_reg;
    logic        seq_done_reg;
    logic        wr_en_reg;
    logic [3:0]  wr_addr_reg;
    logic        issue;
    logic        expire;
    logic        timer_clear;
    logic        timer_run;

    assign issue       = (state_reg == ST_FETCH) && (cnt_reg < 5'(FRAME_WORDS));
    assign timer_run   = (state_reg == ST_HOLD);
    assign timer_clear = (state_reg != ST_HOLD) || Stop_Sig;

    assign Rom_Addr       = ROM_AW'({frame_reg, cnt_reg[3:0]});
    assign Frame_Idx      = frame_reg;
    assign Busy           = (state_reg != ST_IDLE);
    assign Frame_Done_Sig = frame_done_reg;
    assign Seq_Done_Sig   = seq_done_reg;

    ms_timer #(.CLK_PER_MS(CLK_PER_MS)) u_ms_timer (
        .CLK_40Mhz (CLK_40Mhz),
        .RSTn      (RSTn),
        .clear     (timer_clear),
        .run       (timer_run),
        .hold_ms   (hold_reg),
        .expire    (expire)
    );

    // Sequencer FSM: IDLE -> FETCH (17 cycles) -> HOLD -> next frame / IDLE; Stop wins everywhere.
    always_ff @(posedge CLK_40Mhz or negedge RSTn) begin
        if (!RSTn) begin
            state_reg      <= ST_IDLE;
            frame_reg      <= '0;
            last_reg       <= '0;
            hold_reg       <= '0;
            cnt_reg        <= '0;
            frame_done_reg <= 1'b0;
            seq_done_reg   <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            seq_done_reg   <= 1'b0;
            if (Stop_Sig) begin
                state_reg <= ST_IDLE;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (Start_Sig) begin
                            state_reg <= ST_FETCH;
                            frame_reg <= '0;
                            cnt_reg   <= '0;
                            last_reg  <= Frame_Last;
                            hold_reg  <= Hold_Ms;
                        end
                    end
                    ST_FETCH: begin
                        if (cnt_reg == 5'(FRAME_WORDS)) begin
                            state_reg      <= ST_HOLD;
                            cnt_reg        <= '0;
                            frame_done_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 5'd1;
                        end
                    end
                    ST_HOLD: begin
                        if (expire) begin
                            if (frame_reg < last_reg) begin
                                frame_reg <= frame_reg + 3'd1;
                                state_reg <= ST_FETCH;
                            end else if (Loop_En) begin
                                frame_reg <= '0;
                                state_reg <= ST_FETCH;
                            end else begin
                                state_reg    <= ST_IDLE;
                                seq_done_reg <= 1'b1;
                            end
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    // Write stage: delay issue/word index one cycle to meet the ROM data.
    always_ff @(posedge CLK_40Mhz or negedge RSTn) begin
        if (!RSTn) begin
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
        end else begin
            wr_en_reg   <= issue && !Stop_Sig;
            wr_addr_reg <= cnt_reg[3:0];
        end
    end

`ifdef FRAME_SEQ_HOST_PORT_EN
    logic        host_ack_reg;
    logic [3:0]  host_addr_reg;
    logic [15:0] host_data_reg;
    logic        grant_ok;

    // Grant only when the next cycle is certainly not FETCH, so the host
    // never shares a cycle with a sequencer write.
    assign grant_ok = ((state_reg == ST_IDLE) && !(Start_Sig && !Stop_Sig)) ||
                      ((state_reg == ST_HOLD) && (!expire || Stop_Sig));

    // Host grant register: ack and the host word go to the RAM port together.
    always_ff @(posedge CLK_40Mhz or negedge RSTn) begin
        if (!RSTn) begin
            host_ack_reg  <= 1'b0;
            host_addr_reg <= '0;
            host_data_reg <= '0;
        end else begin
            host_ack_reg  <= Host_Req && grant_ok && !wr_en_reg;
            host_addr_reg <= Host_Addr;
            host_data_reg <= Host_Data;
        end
    end

    assign Host_Ack       = host_ack_reg;
    assign Write_En_Sig   = wr_en_reg | host_ack_reg;
    assign Write_Addr_Sig = host_ack_reg ? host_addr_reg : wr_addr_reg;
    assign Write_Data     = host_ack_reg ? host_data_reg : Rom_Data;
`else
    assign Write_En_Sig   = wr_en_reg;
    assign Write_Addr_Sig = wr_addr_reg;
    assign Write_Data     = Rom_Data;
`endif

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Scoreboard bench for vga_frame_sequencer with CLK_PER_MS=4 and a
// synchronous ROM model holding word = address. Host-port cases are
// compiled in when FRAME_SEQ_HOST_PORT_EN is defined.
module tb_vga_frame_sequencer;

    localparam int CPM = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_sig = 1'b0;
    logic        stop_sig = 1'b0;
    logic [2:0]  frame_last = '0;
    logic [9:0]  hold_ms = '0;
    logic        loop_en = 1'b0;
    logic [6:0]  rom_addr;
    logic [15:0] rom_data;
    logic        write_en;
    logic [3:0]  write_addr;
    logic [15:0] write_data;
    logic [2:0]  frame_idx;
    logic        busy;
    logic        frame_done;
    logic        seq_done;
`ifdef FRAME_SEQ_HOST_PORT_EN
    logic        host_req = 1'b0;
    logic [3:0]  host_addr = '0;
    logic [15:0] host_data = '0;
    logic        host_ack;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_fd[$];
    int  exp_sd[$];

    vga_frame_sequencer #(.CLK_PER_MS(CPM)) dut (
        .CLK_40Mhz      (clk),
        .RSTn           (rstn),
        .Start_Sig      (start_sig),
        .Stop_Sig       (stop_sig),
        .Frame_Last     (frame_last),
        .Hold_Ms        (hold_ms),
        .Loop_En        (loop_en),
        .Rom_Addr       (rom_addr),
        .Rom_Data       (rom_data),
        .Write_En_Sig   (write_en),
        .Write_Addr_Sig (write_addr),
        .Write_Data     (write_data),
        .Frame_Idx      (frame_idx),
        .Busy           (busy),
        .Frame_Done_Sig (frame_done),
        .Seq_Done_Sig   (seq_done)
`ifdef FRAME_SEQ_HOST_PORT_EN
        ,
        .Host_Req       (host_req),
        .Host_Addr      (host_addr),
        .Host_Data      (host_data),
        .Host_Ack       (host_ack)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous font ROM: word = address, one cycle latency.
    always @(posedge clk) rom_data <= {9'd0, rom_addr};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a write or a pulse.
    always @(negedge clk) begin
        if (rstn) begin
            if (write_en) begin
                $display("wr cyc=%0d addr=%0d data=%0d", cyc, write_addr, write_data);
                if (exp_wr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr %0d data %0d expected none (cyc %0d)",
                             write_addr, write_data, cyc);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(write_addr), 32'(e.addr));
                    check("wr_data", 32'(write_data), 32'(e.data));
                    check("wr_cyc", cyc, e.cyc);
                end
            end
            if (frame_done) begin
                $display("frame_done cyc=%0d frame=%0d", cyc, frame_idx);
                if (exp_fd.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame_done: got pulse expected none (cyc %0d)", cyc);
                end else begin
                    check("fd_cyc", cyc, exp_fd.pop_front());
                end
            end
            if (seq_done) begin
                $display("seq_done cyc=%0d busy=%0d", cyc, busy);
                if (exp_sd.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_seq_done: got pulse expected none (cyc %0d)", cyc);
                end else begin
                    check("sd_cyc", cyc, exp_sd.pop_front());
                    check("sd_busy", 32'(busy), 32'd0);
                end
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Drive a one-cycle start; c0 is the first FETCH cycle.
    task automatic pulse_start(input logic [2:0] last, input logic [9:0] hms,
                               input logic lp, output int c0);
        @(negedge clk);
        frame_last = last;
        hold_ms    = hms;
        loop_en    = lp;
        start_sig  = 1'b1;
        c0         = cyc + 1;
        @(negedge clk);
        start_sig  = 1'b0;
    endtask

    task automatic push_frame(input int frame, input int c0);
        for (int k = 0; k < 16; k++) begin
            wr_t e;
            e.addr = 4'(k);
            e.data = 16'(frame * 16 + k);
            e.cyc  = c0 + 1 + k;
            exp_wr.push_back(e);
        end
        exp_fd.push_back(c0 + 17);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_wr_left"}, exp_wr.size(), 0);
        check({tag, "_fd_left"}, exp_fd.size(), 0);
        check({tag, "_sd_left"}, exp_sd.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int c1;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_wr_en", 32'(write_en), 32'd0);
        check("rst_wr_addr", 32'(write_addr), 32'd0);
        check("rst_frame_idx", 32'(frame_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        check("rst_sd", 32'(seq_done), 32'd0);
        check("rst_wr_data", 32'(write_data), 32'(rom_data));
        rstn = 1'b1;

        // Single frame, 2 ms hold: HOLD of 8 cycles then done.
        pulse_start(3'd0, 10'd2, 1'b0, c0);
        push_frame(0, c0);
        exp_sd.push_back(c0 + 25);
        wait_until(c0 + 27);
        check("t1_busy", 32'(busy), 32'd0);
        check_drained("t1");

        // Three frames, 1 ms hold: 21-cycle frame period.
        pulse_start(3'd2, 10'd1, 1'b0, c0);
        for (int f = 0; f < 3; f++) push_frame(f, c0 + 21 * f);
        exp_sd.push_back(c0 + 63);
        wait_until(c0 + 60);
        check("t2_frame_idx", 32'(frame_idx), 32'd2);
        wait_until(c0 + 66);
        check("t2_busy", 32'(busy), 32'd0);
        check_drained("t2");

        // Loop over all 8 frames with zero hold, wrap 7 -> 0, stop in the 9th HOLD.
        pulse_start(3'd7, 10'd0, 1'b1, c0);
        for (int f = 0; f < 9; f++) push_frame(f % 8, c0 + 18 * f);
        wait_until(c0 + 18 * 8 + 17);
        stop_sig = 1'b1;
        @(negedge clk);
        stop_sig = 1'b0;
        check("t3_busy", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        loop_en = 1'b0;
        check_drained("t3");

        // Stop while writing word 5 of frame 1, then restart from frame 0.
        pulse_start(3'd2, 10'd0, 1'b0, c0);
        push_frame(0, c0);
        for (int k = 0; k < 6; k++) begin
            wr_t e;
            e.addr = 4'(k);
            e.data = 16'(16 + k);
            e.cyc  = c0 + 19 + k;
            exp_wr.push_back(e);
        end
        wait_until(c0 + 24);
        stop_sig = 1'b1;
        @(negedge clk);
        stop_sig = 1'b0;
        check("t4_wr_en_after_stop", 32'(write_en), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        pulse_start(3'd0, 10'd0, 1'b0, c1);
        push_frame(0, c1);
        exp_sd.push_back(c1 + 18);
        wait_until(c1 + 21);
        check_drained("t4");

        // Start together with Stop from IDLE, then Start while busy.
        @(negedge clk);
        start_sig = 1'b1;
        stop_sig  = 1'b1;
        @(negedge clk);
        start_sig = 1'b0;
        stop_sig  = 1'b0;
        check("t5_start_stop_busy", 32'(busy), 32'd0);
        pulse_start(3'd0, 10'd0, 1'b0, c0);
        push_frame(0, c0);
        exp_sd.push_back(c0 + 18);
        wait_until(c0 + 5);
        frame_last = 3'd3;
        hold_ms    = 10'd5;
        start_sig  = 1'b1;
        @(negedge clk);
        start_sig  = 1'b0;
        wait_until(c0 + 22);
        check("t5_busy", 32'(busy), 32'd0);
        check_drained("t5");

`ifdef FRAME_SEQ_HOST_PORT_EN
        // Host requests: refused during FETCH, granted in HOLD.
        pulse_start(3'd0, 10'd2, 1'b0, c0);
        push_frame(0, c0);
        exp_sd.push_back(c0 + 25);
        wait_until(c0 + 2);
        host_req  = 1'b1;
        host_addr = 4'd9;
        host_data = 16'hBEEF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("h_fetch_ack", 32'(host_ack), 32'd0);
        end
        host_req = 1'b0;
        wait_until(c0 + 18);
        host_req  = 1'b1;
        host_addr = 4'd6;
        host_data = 16'hA5C3;
        begin
            wr_t e;
            e.addr = 4'd6;
            e.data = 16'hA5C3;
            e.cyc  = c0 + 19;
            exp_wr.push_back(e);
        end
        @(negedge clk);
        host_req = 1'b0;
        check("h_hold_ack", 32'(host_ack), 32'd1);
        wait_until(c0 + 28);
        check_drained("h1");

        // Asynchronous reset in the middle of FETCH.
        pulse_start(3'd0, 10'd0, 1'b0, c0);
        wait_until(c0 + 5);
        #2;
        exp_wr.delete();
        exp_fd.delete();
        exp_sd.delete();
        rstn = 1'b0;
        #1;
        check("h_rst_rom_addr", 32'(rom_addr), 32'd0);
        check("h_rst_wr_en", 32'(write_en), 32'd0);
        check("h_rst_wr_addr", 32'(write_addr), 32'd0);
        check("h_rst_busy", 32'(busy), 32'd0);
        check("h_rst_fd", 32'(frame_done), 32'd0);
        check("h_rst_sd", 32'(seq_done), 32'd0);
        check("h_rst_ack", 32'(host_ack), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        check_drained("h2");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_frame_sequencer.md
# vga_frame_sequencer

Sequencer that streams 16-word glyph frames from the 128×16 font ROM into the 16×16 frame RAM of `vga_interface`, frame by frame, with a programmable millisecond hold between frames. It sits between the ROM and the `vga_interface` write port in place of hand-written demo sequencing. It corrects the ROM read latency so that each word lands at its matching RAM address. It optionally arbitrates that write port with a host writer.

## Interface
Parameters:
- `CLK_PER_MS`, 40000: clock cycles per millisecond; 40 MHz gives 40000.
- `FRAME_WORDS`, 16: words per frame; fixed at 16, equal to the RAM depth.
- `ROM_AW`, 7: ROM address width; 8 frames × 16 words.

Ports:
- `CLK_40Mhz` in 1: clock; all logic on the rising edge.
- `RSTn` in 1: reset, asynchronous, active-low.
- `Start_Sig` in 1: one-cycle pulse that starts the sequence; ignored while `Busy`.
- `Stop_Sig` in 1: one-cycle pulse that aborts the sequence; dominates `Start_Sig`.
- `Frame_Last` in 3: index of the last frame; latched on start.
- `Hold_Ms` in 10: hold time per frame in milliseconds; latched on start.
- `Loop_En` in 1: wrap to frame 0 after the last frame; sampled at the end of each last-frame hold.
- `Rom_Addr` out 7: ROM address, `{frame, word}`.
- `Rom_Data` in 16: ROM output, valid 1 cycle after `Rom_Addr`.
- `Write_En_Sig` out 1: RAM write enable.
- `Write_Addr_Sig` out 4: RAM address.
- `Write_Data` out 16: RAM data.
- `Frame_Idx` out 3: current frame number.
- `Busy` out 1: high in any state other than IDLE.
- `Frame_Done_Sig` out 1: one-cycle pulse when a frame is fully written.
- `Seq_Done_Sig` out 1: one-cycle pulse at natural end of sequence (not on Stop).

## Operation
- States are IDLE, FETCH, HOLD.
  - IDLE → FETCH on `Start_Sig`. The frame number resets to 0; `Frame_Last` and `Hold_Ms` are latched.
  - FETCH issues word counter k = 0..15 on `Rom_Addr = frame*16 + k`. It moves to HOLD after k = 15 plus one drain cycle, 17 cycles in total.
  - HOLD counts the ms prescaler 0..`CLK_PER_MS`-1 and the ms counter up to the latched `Hold_Ms`.
  - HOLD at its end:
    - if frame < last: frame increments and the state goes to FETCH;
    - if frame == last and `Loop_En`: frame goes to 0 and the state goes to FETCH;
    - otherwise the state goes to IDLE and `Seq_Done_Sig` pulses.
- Write pipeline:
  - The issue-valid and k are registered one stage.
  - `Write_En_Sig` and `Write_Addr_Sig` come from that stage.
  - `Write_Data` = `Rom_Data`, passed combinationally, so it aligns with the synchronous ROM.
- `Hold_Ms` = 0: HOLD lasts exactly 1 cycle.
- `Frame_Last` = 7 with `ROM_AW` = 7: frame wraps 7 → 0; the address never exceeds 127.
- `Stop_Sig` in any state:
  - next state is IDLE; `Write_En_Sig` is low from the next cycle;
  - no `Frame_Done_Sig` or `Seq_Done_Sig` pulse;
  - a partially written frame stays in RAM.
- `Start_Sig` in IDLE while `Stop_Sig` is high in the same cycle: the block stays in IDLE.
- Reset mid-operation: immediate return to the reset values below.

## Timing
- Reset values:
  - state IDLE;
  - `Rom_Addr`=0, `Write_En_Sig`=0, `Write_Addr_Sig`=0, `Frame_Idx`=0;
  - `Busy`=0, `Frame_Done_Sig`=0, `Seq_Done_Sig`=0;
  - all counters 0;
  - `Write_Data` follows `Rom_Data`.
- `Start_Sig` sampled at edge n gives FETCH cycle c0 = n+1.
- `Rom_Addr` = base+k during c0+k, for k = 0..15.
- `Write_En_Sig` is high during c0+1..c0+16, with `Write_Addr_Sig` = 0..15.
- `Frame_Done_Sig` is high at c0+17, the first HOLD cycle.
- Next FETCH starts at c0+17+max(1, `Hold_Ms`×`CLK_PER_MS`).
- `Seq_Done_Sig` pulses in the cycle after the final HOLD cycle, with `Busy` already 0.

## Configuration
- `FRAME_SEQ_HOST_PORT_EN` defined: adds ports `Host_Req` in 1, `Host_Addr` in 4, `Host_Data` in 16, `Host_Ack` out 1.
  - A host request is granted only in IDLE or HOLD, and only when no sequencer write is pending.
  - On grant, `Host_Ack` and the host write appear on the RAM port in the same cycle, so one word is written per ack cycle.
  - During FETCH the sequencer has fixed priority and `Host_Ack` stays 0.
  - `Host_Ack` resets to 0.
- Not defined: no host ports; the write port is driven only by the sequencer.

## Structure
- Shared package `vga_seq_pkg`:
  - state encoding (IDLE=0, FETCH=1, HOLD=2);
  - `FRAME_WORDS`;
  - default `CLK_PER_MS`.
- One sub-module, `ms_timer`: the prescaler plus ms counter, with inputs clear, run, `Hold_Ms` and output expire-pulse.
- All other logic is in the top module.

## Test plan
The bench sets `CLK_PER_MS`=4 and loads the ROM with word = address.
- Start, `Frame_Last`=0, `Hold_Ms`=2, `Loop_En`=0:
  - 16 writes, addr 0..15 with data 0..15;
  - `Frame_Done_Sig` at c0+17;
  - `Seq_Done_Sig` 8 cycles later;
  - `Busy` low afterwards.
- `Frame_Last`=2, `Hold_Ms`=1:
  - frames 0,1,2 write data 0..15, 16..31, 32..47 to RAM addr 0..15;
  - FETCH starts spaced 21 cycles apart.
- `Loop_En`=1, `Frame_Last`=7, `Hold_Ms`=0:
  - after frame 7 (data 112..127) the next frame writes data 0;
  - frame period 18 cycles.
- `Stop_Sig` at write k=5:
  - `Write_En_Sig` low on the next cycle;
  - no done pulses;
  - `Busy`=0;
  - a fresh Start restarts at frame 0.
- `Start_Sig` and `Stop_Sig` in the same cycle from IDLE: `Busy` stays 0; `Start_Sig` while `Busy` is ignored.
- With `FRAME_SEQ_HOST_PORT_EN`:
  - `Host_Req` during FETCH gives `Host_Ack`=0;
  - during HOLD `Host_Ack`=1 and the host addr/data appear on the write port;
  - asserting RSTn low mid-FETCH forces all outputs to 0.
